// File: rtl/alu_operand_stage_if.sv
// Operation encoding and bundled decode/forwarding/ALU-side signals for alu_operand_stage.
// slave is the stage's view; master is the driver/consumer view.
package alu_operand_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_SLL,
        ALU_OP_SLT,
        ALU_OP_SLTU,
        ALU_OP_XOR,
        ALU_OP_SRL,
        ALU_OP_SRA,
        ALU_OP_OR,
        ALU_OP_AND
    } alu_op_e;
endpackage

interface alu_operand_stage_if;
    import alu_operand_pkg::*;

    logic        in_valid;
    logic        in_ready;
    alu_op_e     in_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        in_rs1_used;
    logic        in_rs2_used;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [31:0] in_pc;
    logic        in_use_pc;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic        flush;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_val;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] store_data;

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_rs1_used,
               in_rs2_used, in_imm, in_use_imm, in_pc, in_use_pc, in_rd, in_is_load, flush,
               mem_fwd_en, mem_fwd_rd, mem_fwd_val, wb_fwd_en, wb_fwd_rd, wb_fwd_val, out_ready,
        output in_ready, out_valid, a, b, op, rd, is_load, store_data
    );

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_rs1_used,
               in_rs2_used, in_imm, in_use_imm, in_pc, in_use_pc, in_rd, in_is_load, flush,
               mem_fwd_en, mem_fwd_rd, mem_fwd_val, wb_fwd_en, wb_fwd_rd, wb_fwd_val, out_ready,
        input  in_ready, out_valid, a, b, op, rd, is_load, store_data
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Single-entry decode-to-ALU register with MEM/WB forwarding, imm/PC operand mux
// and load-use bubble insertion.
module alu_operand_stage
    import alu_operand_pkg::*;
(
    input logic                clk,
    input logic                rst,
    alu_operand_stage_if.slave bus
);

    logic        valid_q, valid_d;
    alu_op_e     op_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic [31:0] rs1_val_q, rs2_val_q, imm_q, pc_q;
    logic        use_imm_q, use_pc_q, is_load_q;

    logic        hazard;
    logic        capture;
    logic [31:0] rs1_fwd, rs2_fwd, b_sel;

    always_comb begin
        hazard = valid_q & is_load_q & (rd_q != 5'd0) &
                 ((bus.in_rs1_used & (bus.in_rs1 == rd_q)) |
                  (bus.in_rs2_used & (bus.in_rs2 == rd_q)));
        bus.in_ready = (~valid_q | bus.out_ready) & ~hazard;
        capture = bus.in_valid & bus.in_ready & ~bus.flush;
    end

    always_comb begin
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            op_q      <= ALU_OP_ADD;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            rs1_val_q <= 32'd0;
            rs2_val_q <= 32'd0;
            imm_q     <= 32'd0;
            pc_q      <= 32'd0;
            use_imm_q <= 1'b0;
            use_pc_q  <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                op_q      <= bus.in_op;
                rs1_q     <= bus.in_rs1;
                rs2_q     <= bus.in_rs2;
                rd_q      <= bus.in_rd;
                rs1_val_q <= bus.in_rs1_val;
                rs2_val_q <= bus.in_rs2_val;
                imm_q     <= bus.in_imm;
                pc_q      <= bus.in_pc;
                use_imm_q <= bus.in_use_imm;
                use_pc_q  <= bus.in_use_pc;
                is_load_q <= bus.in_is_load;
            end
        end
    end

    // MEM beats WB; x0 reads as zero whatever was captured or forwarded.
    always_comb begin
        rs1_fwd = rs1_val_q;
        if (rs1_q == 5'd0) begin
            rs1_fwd = 32'd0;
        end else if (bus.mem_fwd_en && bus.mem_fwd_rd == rs1_q) begin
            rs1_fwd = bus.mem_fwd_val;
        end else if (bus.wb_fwd_en && bus.wb_fwd_rd == rs1_q) begin
            rs1_fwd = bus.wb_fwd_val;
        end

        rs2_fwd = rs2_val_q;
        if (rs2_q == 5'd0) begin
            rs2_fwd = 32'd0;
        end else if (bus.mem_fwd_en && bus.mem_fwd_rd == rs2_q) begin
            rs2_fwd = bus.mem_fwd_val;
        end else if (bus.wb_fwd_en && bus.wb_fwd_rd == rs2_q) begin
            rs2_fwd = bus.wb_fwd_val;
        end
    end

    always_comb begin
        b_sel = use_imm_q ? imm_q : rs2_fwd;
        bus.a = use_pc_q ? pc_q : rs1_fwd;
        unique case (op_q)
            ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: bus.b = {27'd0, b_sel[4:0]};
            default:                            bus.b = b_sel;
        endcase
        bus.store_data = rs2_fwd;
        bus.out_valid  = valid_q;
        bus.op         = op_q;
        bus.rd         = rd_q;
        bus.is_load    = is_load_q;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized bench for alu_operand_stage against a transaction-level model
// of the held entry.
module tb_alu_operand_stage;
    import alu_operand_pkg::*;

    typedef struct packed {
        alu_op_e     op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] imm;
        logic        use_imm;
        logic [31:0] pc;
        logic        use_pc;
        logic [4:0]  rd;
        logic        is_load;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    instr_t m;        // model of the held entry
    logic   m_valid;
    instr_t drv;      // instruction currently presented by decode

    function automatic instr_t mk(alu_op_e op, logic [4:0] rs1, logic [31:0] v1,
                                  logic [4:0] rs2, logic [31:0] v2, logic [4:0] rd);
        instr_t i;
        i          = '0;
        i.op       = op;
        i.rs1      = rs1;
        i.rs1_val  = v1;
        i.rs2      = rs2;
        i.rs2_val  = v2;
        i.rs1_used = 1'b1;
        i.rs2_used = 1'b1;
        i.rd       = rd;
        return i;
    endfunction

    task automatic apply(instr_t i);
        drv             = i;
        bus.in_op       = i.op;
        bus.in_rs1      = i.rs1;
        bus.in_rs2      = i.rs2;
        bus.in_rs1_val  = i.rs1_val;
        bus.in_rs2_val  = i.rs2_val;
        bus.in_rs1_used = i.rs1_used;
        bus.in_rs2_used = i.rs2_used;
        bus.in_imm      = i.imm;
        bus.in_use_imm  = i.use_imm;
        bus.in_pc       = i.pc;
        bus.in_use_pc   = i.use_pc;
        bus.in_rd       = i.rd;
        bus.in_is_load  = i.is_load;
    endtask

    task automatic fwd_set(logic me, logic [4:0] mr, logic [31:0] mv,
                           logic we, logic [4:0] wr, logic [31:0] wv);
        bus.mem_fwd_en  = me;
        bus.mem_fwd_rd  = mr;
        bus.mem_fwd_val = mv;
        bus.wb_fwd_en   = we;
        bus.wb_fwd_rd   = wr;
        bus.wb_fwd_val  = wv;
    endtask

    function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] held);
        if (idx == 5'd0) return 32'd0;
        if (bus.mem_fwd_en && bus.mem_fwd_rd == idx) return bus.mem_fwd_val;
        if (bus.wb_fwd_en && bus.wb_fwd_rd == idx) return bus.wb_fwd_val;
        return held;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the model, then advance one clock and the model with it.
    task automatic step(string tag);
        logic        hz, rdy, nv;
        logic [31:0] ea, eb, sd;
        instr_t      nm;
        #1;
        hz  = m_valid && m.is_load && m.rd != 5'd0 &&
              ((drv.rs1_used && drv.rs1 == m.rd) || (drv.rs2_used && drv.rs2 == m.rd));
        rdy = (!m_valid || bus.out_ready) && !hz;
        sd  = fwd(m.rs2, m.rs2_val);
        ea  = m.use_pc ? m.pc : fwd(m.rs1, m.rs1_val);
        eb  = m.use_imm ? m.imm : sd;
        if (m.op inside {ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA}) eb = eb % 32;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".a"}, bus.a, ea);
        chk({tag, ".b"}, bus.b, eb);
        chk({tag, ".op"}, 32'(bus.op), 32'(m.op));
        chk({tag, ".rd"}, 32'(bus.rd), 32'(m.rd));
        chk({tag, ".is_load"}, 32'(bus.is_load), 32'(m.is_load));
        chk({tag, ".store_data"}, bus.store_data, sd);
        nv = m_valid;
        nm = m;
        if (bus.flush) begin
            nv = 1'b0;
        end else if (bus.in_valid && rdy) begin
            nv = 1'b1;
            nm = drv;
        end else if (bus.out_ready) begin
            nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        m       = nm;
    endtask

    initial begin
        instr_t t;
        rst           = 1'b1;
        m_valid       = 1'b0;
        m             = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        apply('0);
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset values
        #3;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.a", bus.a, 32'd0);
        chk("rst.b", bus.b, 32'd0);
        chk("rst.op", 32'(bus.op), 32'(ALU_OP_ADD));
        chk("rst.store_data", bus.store_data, 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back stream
        apply(mk(ALU_OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3));
        bus.in_valid = 1'b1;
        step("b2b0");
        chk("b2b.a", bus.a, 32'd5);
        chk("b2b.b", bus.b, 32'd7);
        chk("b2b.op", 32'(bus.op), 32'(ALU_OP_ADD));
        apply(mk(ALU_OP_SUB, 5'd1, 32'd9, 5'd2, 32'd4, 5'd4));
        step("b2b1");
        chk("b2b.op2", 32'(bus.op), 32'(ALU_OP_SUB));
        chk("b2b.valid2", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        step("b2b2");

        // Forwarding priority
        apply(mk(ALU_OP_ADD, 5'd3, 32'd1, 5'd0, 32'd0, 5'd6));
        bus.in_valid = 1'b1;
        step("fwd0");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        fwd_set(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        #1 chk("fwd.mem", bus.a, 32'h10);
        step("fwd1");
        bus.mem_fwd_en = 1'b0;
        #1 chk("fwd.wb", bus.a, 32'h20);
        step("fwd2");
        bus.out_ready = 1'b1;
        apply(mk(ALU_OP_ADD, 5'd0, 32'h55, 5'd0, 32'h66, 5'd6));
        bus.in_valid = 1'b1;
        step("fwd3");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        fwd_set(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hFF);
        #1 chk("fwd.x0", bus.a, 32'd0);
        step("fwd4");
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.out_ready = 1'b1;
        step("fwd5");

        // Load-use bubble
        t         = mk(ALU_OP_ADD, 5'd1, 32'd0, 5'd2, 32'd0, 5'd5);
        t.is_load = 1'b1;
        apply(t);
        bus.in_valid = 1'b1;
        step("lu0");
        apply(mk(ALU_OP_ADD, 5'd5, 32'h1111, 5'd0, 32'd0, 5'd7));
        #1 chk("lu.stall", 32'(bus.in_ready), 32'd0);
        step("lu1");
        chk("lu.bubble", 32'(bus.out_valid), 32'd0);
        chk("lu.ready1", 32'(bus.in_ready), 32'd1);
        step("lu2");
        bus.in_valid = 1'b0;
        fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hABCD);
        #1 chk("lu.wb_a", bus.a, 32'hABCD);
        step("lu3");
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Backpressure then flush
        apply(mk(ALU_OP_XOR, 5'd8, 32'h8, 5'd9, 32'h9, 5'd10));
        bus.in_valid = 1'b1;
        step("bp0");
        bus.out_ready = 1'b0;
        apply(mk(ALU_OP_OR, 5'd11, 32'hB, 5'd12, 32'hC, 5'd13));
        for (int i = 0; i < 3; i++) begin
            step("bp");
            chk("bp.rd_held", 32'(bus.rd), 32'd10);
        end
        bus.flush = 1'b1;
        step("fl0");
        chk("fl.valid", 32'(bus.out_valid), 32'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step("fl1");

        // Immediate / PC / shift masking
        t         = mk(ALU_OP_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1);
        t.use_pc  = 1'b1;
        t.pc      = 32'h100;
        t.use_imm = 1'b1;
        t.imm     = 32'h1000;
        apply(t);
        bus.in_valid = 1'b1;
        step("auipc");
        chk("auipc.a", bus.a, 32'h100);
        chk("auipc.b", bus.b, 32'h1000);
        apply(mk(ALU_OP_SLL, 5'd1, 32'd1, 5'd7, 32'h23, 5'd2));
        step("sll");
        chk("sll.b", bus.b, 32'd3);
        apply(mk(ALU_OP_SUB, 5'd1, 32'd1, 5'd7, 32'h23, 5'd2));
        step("sub");
        chk("sub.b", bus.b, 32'h23);

        // Asynchronous reset between edges
        apply(mk(ALU_OP_AND, 5'd4, 32'h44, 5'd5, 32'h55, 5'd6));
        #1 rst = 1'b1;
        #1;
        chk("arst.valid", 32'(bus.out_valid), 32'd0);
        chk("arst.a", bus.a, 32'd0);
        chk("arst.op", 32'(bus.op), 32'(ALU_OP_ADD));
        m_valid = 1'b0;
        m       = '0;
        #1 rst  = 1'b0;
        step("arst0");
        chk("arst.cap_a", bus.a, 32'h44);
        step("arst1");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            t          = '0;
            t.op       = alu_op_e'($urandom_range(0, 9));
            t.rs1      = 5'($urandom_range(0, 7));
            t.rs2      = 5'($urandom_range(0, 7));
            t.rs1_val  = $urandom;
            t.rs2_val  = $urandom;
            t.rs1_used = 1'($urandom_range(0, 1));
            t.rs2_used = 1'($urandom_range(0, 1));
            t.imm      = $urandom;
            t.use_imm  = 1'($urandom_range(0, 1));
            t.pc       = $urandom;
            t.use_pc   = 1'($urandom_range(0, 1));
            t.rd       = 5'($urandom_range(0, 7));
            t.is_load  = 1'($urandom_range(0, 2) == 0);
            apply(t);
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            bus.flush     = 1'($urandom_range(0, 15) == 0);
            fwd_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
